// File: rtl/pic_plotter_if.sv
// pic_plotter_if: ROM-loader read port, VGA write port and frame control for pic_plotter.
interface pic_plotter_if;
  logic       start;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [2:0] rom_q;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  modport master (output start, rom_q, input rd_x, rd_y, vga_x, vga_y, colour, plot, busy, done);
  modport slave  (input start, rom_q, output rd_x, rd_y, vga_x, vga_y, colour, plot, busy, done);
endinterface

// File: rtl/pic_plotter.sv
// pic_plotter: full-screen blitter sweeping a WIDTH x HEIGHT raster through a picture ROM into the VGA port.
// Define PIC_PLOTTER_TRANSPARENT_EN to suppress writes of pixels whose colour equals TRANS_COLOUR.
module pic_plotter #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter int         ROM_LAT      = 1,
  parameter logic [2:0] TRANS_COLOUR = 3'b000
) (
  input logic         clk,
  input logic         reset,
  pic_plotter_if.slave bus
);
`ifdef PIC_PLOTTER_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] rd_x_q, rd_x_d;
  logic [6:0] rd_y_q, rd_y_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  logic [7:0] px_q [ROM_LAT];
  logic [7:0] px_d [ROM_LAT];
  logic [6:0] py_q [ROM_LAT];
  logic [6:0] py_d [ROM_LAT];
  logic scan, x_end, last, done;
  assign scan  = state_q == SCAN;
  assign x_end = rd_x_q == 8'(WIDTH - 1);
  assign last  = x_end && rd_y_q == 7'(HEIGHT - 1);
  assign bus.rd_x   = rd_x_q;
  assign bus.rd_y   = rd_y_q;
  assign bus.vga_x  = px_q[ROM_LAT-1];
  assign bus.vga_y  = py_q[ROM_LAT-1];
  assign bus.colour = bus.rom_q;
  assign bus.busy   = state_q != IDLE;
  assign done       = vld_q[ROM_LAT-1] && px_q[ROM_LAT-1] == 8'(WIDTH - 1) && py_q[ROM_LAT-1] == 7'(HEIGHT - 1);
  assign bus.done   = done;
  // a suppressed pixel still advances coordinates and still raises done
  assign bus.plot   = vld_q[ROM_LAT-1] && !(TRANSP_EN && bus.rom_q == TRANS_COLOUR);
  always_comb begin
    state_d = state_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    if (state_q == IDLE && bus.start) state_d = SCAN;
    if (scan) begin
      rd_x_d = x_end ? 8'd0 : rd_x_q + 8'd1;
      rd_y_d = last ? 7'd0 : rd_y_q + 7'(x_end);
      if (last) state_d = DRAIN;
    end
    if (state_q == DRAIN && done) state_d = IDLE;
    vld_d    = '0;
    vld_d[0] = scan;
    px_d[0]  = scan ? rd_x_q : px_q[0];
    py_d[0]  = scan ? rd_y_q : py_q[0];
    for (int k = 1; k < ROM_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      px_d[k]  = vld_q[k-1] ? px_q[k-1] : px_q[k];
      py_d[k]  = vld_q[k-1] ? py_q[k-1] : py_q[k];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      vld_q   <= '0;
      px_q    <= '{default: '0};
      py_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      vld_q   <= vld_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end
endmodule

// File: tb/tb_pic_plotter.sv
// tb_pic_plotter: runs ROM_LAT=1 and ROM_LAT=3 plotters side by side against a frame-timing model.
module tb_pic_plotter;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
`ifdef PIC_PLOTTER_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  localparam int NP = TR ? N / 2 : N;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pic_plotter_if i0 ();
  pic_plotter_if i1 ();
  pic_plotter #(.WIDTH(W), .HEIGHT(H), .ROM_LAT(1)) d0 (.clk(clk), .reset(reset), .bus(i0.slave));
  pic_plotter #(.WIDTH(W), .HEIGHT(H), .ROM_LAT(3)) d1 (.clk(clk), .reset(reset), .bus(i1.slave));
  function automatic logic [2:0] rom_f(input int x, input int y);
    if (TR) return (x % 2 == 0) ? 3'd0 : 3'd5;
    return 3'((x + y) % 8);
  endfunction
  logic [7:0] q0x;
  logic [6:0] q0y;
  logic [7:0] q1x [3];
  logic [6:0] q1y [3];
  always @(posedge clk) begin
    q0x    <= i0.rd_x;
    q0y    <= i0.rd_y;
    q1x[0] <= i1.rd_x;
    q1y[0] <= i1.rd_y;
    q1x[1] <= q1x[0];
    q1y[1] <= q1y[0];
    q1x[2] <= q1x[1];
    q1y[2] <= q1y[1];
  end
  assign i0.rom_q = rom_f(int'(q0x), int'(q0y));
  assign i1.rom_q = rom_f(int'(q1x[2]), int'(q1y[2]));
  int total = 0;
  int bad = 0;
  int lat [2] = '{1, 3};
  int t [2] = '{0, 0};
  bit act [2] = '{0, 0};
  int lx [2] = '{0, 0};
  int ly [2] = '{0, 0};
  int plots [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int fs [2] = '{0, 0};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_dut(input int m, input logic [7:0] rx, input logic [6:0] ry, input logic [7:0] vx,
                           input logic [6:0] vy, input logic [2:0] col, input logic pl, input logic bs, input logic dn);
    int L, p, ex, ey;
    bit raw;
    logic [2:0] ec;
    L   = lat[m];
    p   = t[m] - L;
    raw = act[m] && t[m] >= L && t[m] < L + N;
    ec  = 3'd0;
    if (raw) begin
      ex = p % W;
      ey = p / W;
      ec = rom_f(ex, ey);
      lx[m] = ex;
      ly[m] = ey;
    end
    chk($sformatf("plot%0d", m), {31'd0, pl}, {31'd0, raw && !(TR && ec == 3'd0)});
    chk($sformatf("busy%0d", m), {31'd0, bs}, {31'd0, act[m]});
    chk($sformatf("done%0d", m), {31'd0, dn}, {31'd0, act[m] && t[m] == L + N - 1});
    chk($sformatf("vga_x%0d", m), {24'd0, vx}, lx[m]);
    chk($sformatf("vga_y%0d", m), {25'd0, vy}, ly[m]);
    if (raw) chk($sformatf("colour%0d", m), {29'd0, col}, {29'd0, ec});
    if (!act[m]) begin
      chk($sformatf("rd_x_idle%0d", m), {24'd0, rx}, 0);
      chk($sformatf("rd_y_idle%0d", m), {25'd0, ry}, 0);
    end else if (t[m] < N) begin
      chk($sformatf("rd_x%0d", m), {24'd0, rx}, t[m] % W);
      chk($sformatf("rd_y%0d", m), {25'd0, ry}, t[m] / W);
    end
    if (pl === 1'b1) plots[m]++;
    if (dn === 1'b1) dones[m]++;
  endtask
  task automatic tick(input bit s0, input bit s1);
    i0.start = s0;
    i1.start = s1;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (reset) continue;
      if (act[m]) begin
        t[m]++;
        if (t[m] == lat[m] + N) act[m] = 1'b0;
      end else if (m == 0 ? s0 : s1) begin
        act[m] = 1'b1;
        t[m]   = 0;
        fs[m]++;
      end
    end
    @(negedge clk);
    check_dut(0, i0.rd_x, i0.rd_y, i0.vga_x, i0.vga_y, i0.colour, i0.plot, i0.busy, i0.done);
    check_dut(1, i1.rd_x, i1.rd_y, i1.vga_x, i1.vga_y, i1.colour, i1.plot, i1.busy, i1.done);
  endtask
  initial begin
    int cyc;
    bit s0, s1;
    i0.start = 1'b0;
    i1.start = 1'b0;
    repeat (2) @(negedge clk);
    check_dut(0, i0.rd_x, i0.rd_y, i0.vga_x, i0.vga_y, i0.colour, i0.plot, i0.busy, i0.done);
    check_dut(1, i1.rd_x, i1.rd_y, i1.vga_x, i1.vga_y, i1.colour, i1.plot, i1.busy, i1.done);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    // two frames: a start re-pulse at pixel (80,60) is ignored, and the second start lands right after done
    cyc = 0;
    while (!(fs[0] == 2 && fs[1] == 2 && !act[0] && !act[1]) && cyc < 45000) begin
      s0 = (!act[0] && fs[0] < 2) || (act[0] && t[0] - lat[0] == 60 * W + 80);
      s1 = (!act[1] && fs[1] < 2) || (act[1] && t[1] - lat[1] == 60 * W + 80);
      tick(s0, s1);
      cyc++;
    end
    chk("ab_in_budget", {31'd0, cyc < 45000}, 1);
    chk("ab_plots0", plots[0], 2 * NP);
    chk("ab_plots1", plots[1], 2 * NP);
    chk("ab_dones0", dones[0], 2);
    chk("ab_dones1", dones[1], 2);
    // abort a frame when the ROM_LAT=1 plotter is writing pixel (10,5)
    tick(1'b1, 1'b1);
    cyc = 0;
    while (!(act[0] && t[0] - lat[0] == 5 * W + 10) && cyc < 2000) begin
      tick(1'b0, 1'b0);
      cyc++;
    end
    chk("c_in_budget", {31'd0, cyc < 2000}, 1);
    reset = 1'b1;
    #1;
    chk("rst_plot0", {31'd0, i0.plot}, 0);
    chk("rst_busy0", {31'd0, i0.busy}, 0);
    chk("rst_done0", {31'd0, i0.done}, 0);
    chk("rst_plot1", {31'd0, i1.plot}, 0);
    chk("rst_busy1", {31'd0, i1.busy}, 0);
    act = '{0, 0};
    lx  = '{0, 0};
    ly  = '{0, 0};
    tick(1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0);
    plots = '{0, 0};
    dones = '{0, 0};
    tick(1'b1, 1'b1);
    cyc = 0;
    while ((act[0] || act[1]) && cyc < 20000) begin
      tick(1'b0, 1'b0);
      cyc++;
    end
    chk("d_in_budget", {31'd0, cyc < 20000}, 1);
    chk("d_plots0", plots[0], NP);
    chk("d_plots1", plots[1], NP);
    chk("d_dones0", dones[0], 1);
    chk("d_dones1", dones[1], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
